// File: rtl/shift_seq_if.sv
// Handshake and data bundle between the execute-path issue logic and the sequential shifter.
interface shift_seq_if;
    logic        ctrl_shift;
    logic        ctrl_sra;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] result;
    logic        resultRDY;
    logic        busy;

    modport master (
        output ctrl_shift, ctrl_sra, data_operand, ctrl_shiftamt,
        input  result, resultRDY, busy
    );

    modport slave (
        input  ctrl_shift, ctrl_sra, data_operand, ctrl_shiftamt,
        output result, resultRDY, busy
    );
endinterface

// File: rtl/shift_seq.sv
// Sequential 32-bit shifter: one 16/8/4/2/1 stage per cycle, MSB of the amount first,
// fixed 5-cycle run followed by a one-cycle ready strobe.
module shift_seq (
    input  logic        clock,
    input  logic        reset,
    shift_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] acc_r;
    logic [4:0]  amt_r;
    logic        dir_r;
    logic [2:0]  cnt_r;
    logic        busy_r;
    logic        rdy_r;
    logic        stage_en_s;

    // Single fixed-width stage; right shifts replicate the sign bit.
    function automatic logic [31:0] stage_shift(input logic [31:0] val,
                                                input logic [2:0]  stage,
                                                input logic        sra);
        logic [31:0] res;
        case (stage)
            3'd0:    res = sra ? {{16{val[31]}}, val[31:16]} : {val[15:0], 16'h0000};
            3'd1:    res = sra ? {{8{val[31]}},  val[31:8]}  : {val[23:0], 8'h00};
            3'd2:    res = sra ? {{4{val[31]}},  val[31:4]}  : {val[27:0], 4'h0};
            3'd3:    res = sra ? {{2{val[31]}},  val[31:2]}  : {val[29:0], 2'b00};
            3'd4:    res = sra ? {val[31],       val[31:1]}  : {val[30:0], 1'b0};
            default: res = val;
        endcase
        return res;
    endfunction

    // Select the amount bit that enables the current stage.
    always_comb begin
        stage_en_s = 1'b0;
        case (cnt_r)
            3'd0:    stage_en_s = amt_r[4];
            3'd1:    stage_en_s = amt_r[3];
            3'd2:    stage_en_s = amt_r[2];
            3'd3:    stage_en_s = amt_r[1];
            3'd4:    stage_en_s = amt_r[0];
            default: stage_en_s = 1'b0;
        endcase
    end

    // Next-state logic; a start in any state (re)enters RUN.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.ctrl_shift) next_state_s = RUN;
                else                next_state_s = IDLE;
            end
            RUN: begin
                if (bus.ctrl_shift)      next_state_s = RUN;
                else if (cnt_r == 3'd4)  next_state_s = DONE;
                else                     next_state_s = RUN;
            end
            DONE: begin
                if (bus.ctrl_shift) next_state_s = RUN;
                else                next_state_s = IDLE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Operand capture and per-cycle stage application.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r <= 32'h0000_0000;
            amt_r <= 5'd0;
            dir_r <= 1'b0;
            cnt_r <= 3'd0;
        end else if (bus.ctrl_shift) begin
            acc_r <= bus.data_operand;
            amt_r <= bus.ctrl_shiftamt;
            dir_r <= bus.ctrl_sra;
            cnt_r <= 3'd0;
        end else if (state_r == RUN) begin
            if (stage_en_s) acc_r <= stage_shift(acc_r, cnt_r, dir_r);
            else            acc_r <= acc_r;
            cnt_r <= cnt_r + 3'd1;
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Status flags registered from the next state so they align with the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r <= 1'b0;
            rdy_r  <= 1'b0;
        end else begin
            busy_r <= (next_state_s == RUN);
            rdy_r  <= (next_state_s == DONE);
        end
    end

    assign bus.result    = acc_r;
    assign bus.resultRDY = rdy_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed, random, restart, back-to-back and reset cases.
module tb_shift_seq;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   rdy_count;
    int   consec_rdy;
    logic prev_rdy;

    shift_seq_if bus ();

    shift_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe bookkeeping observed on the falling edge.
    always @(negedge clock) begin
        if (bus.resultRDY === 1'b1) rdy_count++;
        if (bus.resultRDY === 1'b1 && prev_rdy === 1'b1) consec_rdy++;
        prev_rdy = bus.resultRDY;
    end

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input logic sra);
        logic signed [31:0] sd;
        sd = d;
        if (sra) return sd >>> a;
        else     return d << a;
    endfunction

    task automatic start_op(input logic [31:0] d, input logic [4:0] a, input logic sra);
        bus.data_operand  = d;
        bus.ctrl_shiftamt = a;
        bus.ctrl_sra      = sra;
        bus.ctrl_shift    = 1'b1;
    endtask

    // Steps falling edges after a start until the strobe (idx=0 on timeout).
    task automatic wait_rdy(input int limit, output int idx, output logic [31:0] res, output int busy_n);
        idx = 0; busy_n = 0; res = 32'h0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b1) busy_n++;
            if (i == 1) begin
                bus.ctrl_shift    = 1'b0;
                bus.data_operand  = $urandom;
                bus.ctrl_shiftamt = 5'($urandom);
                bus.ctrl_sra      = 1'($urandom);
            end
            if (bus.resultRDY === 1'b1) begin
                idx = i;
                res = bus.result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ctrl_shift = 1'b1;
        bus.data_operand = 32'hDEAD_BEEF; bus.ctrl_shiftamt = 5'd3; bus.ctrl_sra = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        bus.ctrl_shift = 1'b0;
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=%h", bus.result, 32'h0); end
        checks++; if (bus.resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", bus.resultRDY); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [31:0] vd [6] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hF000_0000, 32'h0000_FFFF};
        logic [4:0]  va [6] = '{5'd8, 5'd31, 5'd31, 5'd31, 5'd0, 5'd16};
        logic        vs [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ve [6] = '{32'hFF80_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hF000_0000, 32'hFFFF_0000};
        int idx, bn;
        logic [31:0] res;
        for (int v = 0; v < 6; v++) begin
            start_op(vd[v], va[v], vs[v]);
            wait_rdy(20, idx, res, bn);
            checks++; if (idx != 6) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=6", v, idx); end
            checks++; if (res !== ve[v]) begin failures++; $display("FAIL dir_result[%0d] got=%h exp=%h", v, res, ve[v]); end
            checks++; if (bn != 5) begin failures++; $display("FAIL dir_busy_cycles[%0d] got=%0d exp=5", v, bn); end
            @(negedge clock);
            checks++; if (bus.result !== ve[v] || bus.resultRDY !== 1'b0) begin
                failures++; $display("FAIL dir_hold[%0d] got=%h rdy=%b exp=%h rdy=0", v, bus.result, bus.resultRDY, ve[v]);
            end
        end
    endtask

    task automatic test_random();
        int idx, bn, a;
        logic [31:0] d, res, exp_v;
        logic s;
        for (int n = 0; n < 40; n++) begin
            d = $urandom; a = $urandom_range(0, 31); s = 1'($urandom);
            exp_v = ref_shift(d, a, s);
            start_op(d, 5'(a), s);
            wait_rdy(20, idx, res, bn);
            checks++; if (idx != 6 || res !== exp_v) begin
                failures++; $display("FAIL rand[%0d] d=%h a=%0d sra=%b got=%h lat=%0d exp=%h lat=6", n, d, a, s, res, idx, exp_v);
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    task automatic test_restart();
        int idx, bn, c0;
        logic [31:0] res;
        #1 c0 = rdy_count;
        start_op(32'h1234_5678, 5'd4, 1'b0);
        @(negedge clock);
        bus.ctrl_shift = 1'b0;
        @(negedge clock);
        start_op(32'h0000_0100, 5'd8, 1'b1);
        wait_rdy(20, idx, res, bn);
        checks++; if (idx != 6) begin failures++; $display("FAIL restart_latency got=%0d exp=6", idx); end
        checks++; if (res !== 32'h0000_0001) begin failures++; $display("FAIL restart_result got=%h exp=%h", res, 32'h1); end
        repeat (4) @(negedge clock);
        #1;
        checks++; if (rdy_count - c0 != 1) begin failures++; $display("FAIL restart_strobes got=%0d exp=1", rdy_count - c0); end
    endtask

    task automatic test_back_to_back();
        int idx, bn, c0;
        logic [31:0] res;
        #1 c0 = consec_rdy;
        start_op(32'hA5A5_0F0F, 5'd12, 1'b1);
        wait_rdy(20, idx, res, bn);
        checks++; if (idx != 6 || res !== ref_shift(32'hA5A5_0F0F, 12, 1'b1)) begin
            failures++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=6", res, idx, ref_shift(32'hA5A5_0F0F, 12, 1'b1));
        end
        start_op(32'h0000_FFFF, 5'd16, 1'b0);
        wait_rdy(20, idx, res, bn);
        checks++; if (idx != 6) begin failures++; $display("FAIL b2b_spacing got=%0d exp=6", idx); end
        checks++; if (res !== 32'hFFFF_0000) begin failures++; $display("FAIL b2b_second got=%h exp=%h", res, 32'hFFFF_0000); end
        repeat (2) @(negedge clock);
        #1;
        checks++; if (consec_rdy != c0) begin failures++; $display("FAIL b2b_consecutive_rdy got=%0d exp=%0d", consec_rdy, c0); end
    endtask

    task automatic test_reset_mid();
        int idx, bn, c0;
        logic [31:0] res;
        start_op(32'h0F0F_1234, 5'd5, 1'b0);
        @(negedge clock);
        bus.ctrl_shift = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1 c0 = rdy_count;
        checks++; if (bus.result !== 32'h0 || bus.resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL midreset_state got=%h rdy=%b busy=%b exp=0 0 0", bus.result, bus.resultRDY, bus.busy);
        end
        repeat (10) @(negedge clock);
        #1;
        checks++; if (rdy_count != c0) begin failures++; $display("FAIL midreset_strobe got=%0d exp=0", rdy_count - c0); end
        @(negedge clock);
        start_op(32'h8765_4321, 5'd7, 1'b1);
        wait_rdy(20, idx, res, bn);
        checks++; if (idx != 6 || res !== ref_shift(32'h8765_4321, 7, 1'b1)) begin
            failures++; $display("FAIL midreset_after got=%h lat=%0d exp=%h lat=6", res, idx, ref_shift(32'h8765_4321, 7, 1'b1));
        end
    endtask

    initial begin
        checks = 0; failures = 0; rdy_count = 0; consec_rdy = 0; prev_rdy = 1'b0;
        reset = 1'b1;
        bus.ctrl_shift = 1'b0; bus.ctrl_sra = 1'b0;
        bus.data_operand = 32'h0; bus.ctrl_shiftamt = 5'd0;
        test_reset();
        test_directed();
        test_random();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
